// File: rtl/shift_add_mult_arbiter.sv
// Round-robin arbiter that shares one sequential shift-add multiplier between
// NUM_REQ requesters, returning the product or a timeout error per requester.
module shift_add_mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_err,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product
);

  // state | meaning
  // IDLE  | search for a valid requester from ptr, accept it
  // ISSUE | mul_start high, counter cleared
  // WAIT  | wait for mul_done or timeout
  // RESP  | present response to granted requester until accepted

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     id;
  logic [CW-1:0]      cnt;

  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic [IDW-1:0]     grant;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  int                 off;
  int                 sum;

  // Rotate so bit 0 is the requester at ptr; lowest set bit wins.
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr);
    found = 1'b0;
    off   = 0;
    sum   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    grant = IDW'(sum);
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == IDW'(k)) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && state == S_IDLE && found) req_ready = NUM_REQ'(1) << grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      id          <= '0;
      cnt         <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            mul_a     <= sel_a;
            mul_b     <= sel_b;
            id        <= grant;
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done has priority over a timeout landing in the same cycle
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            rsp_valid   <= NUM_REQ'(1) << id;
            state       <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= NUM_REQ'(1) << id;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if ((rsp_ready & rsp_valid) != '0) begin
            rsp_valid <= '0;
            if (id == IDW'(NUM_REQ - 1)) ptr <= '0;
            else ptr <= id + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_arbiter.sv
// Directed bench for shift_add_mult_arbiter with a behavioural multiplier
// and a response scoreboard.
module tb_shift_add_mult_arbiter;
  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]       rsp_product;
  logic                     rsp_err;
  logic                     mul_start;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_done;
  logic [2*WIDTH-1:0]       mul_product;

  shift_add_mult_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // Multiplier model: done pulse 'delay' cycles after the start cycle.
  logic       model_en;
  logic       force_done;
  int         delay;
  logic       mdone;
  logic       pend;
  int         mcnt;
  logic [7:0] mprod;

  always @(negedge clk) begin
    if (!rst) begin
      pend  = 1'b0;
      mdone = 1'b0;
    end else begin
      mdone = 1'b0;
      if (pend) begin
        mcnt = mcnt - 1;
        if (mcnt == 0) begin
          mdone = 1'b1;
          pend  = 1'b0;
        end
      end
      if (mul_start && model_en) begin
        pend  = 1'b1;
        mcnt  = delay;
        mprod = 8'(mul_a) * 8'(mul_b);
      end
    end
  end

  assign mul_done    = mdone | force_done;
  assign mul_product = mprod;

  typedef struct {
    int         id;
    logic       err;
    logic [7:0] prod;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 64) begin
      tick();
      n++;
    end
    check("rsp_arrived", 32'(rsp_valid != '0), 1);
  endtask

  task automatic pop_check();
    exp_t e;
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_valid", rsp_valid, 1 << e.id);
      check("rsp_err", rsp_err, e.err);
      check("rsp_product", rsp_product, e.prod);
    end
  endtask

  // Caller sets req_valid/operands just after an edge; returns in RESP.
  task automatic op(input int g, input logic [3:0] a, input logic [3:0] b,
                    input logic err, input int lat, input bit drop);
    int         n;
    logic [7:0] p;
    p = err ? 8'd0 : 8'(a) * 8'(b);
    #1;
    check("req_ready", req_ready, 1 << g);
    sb.push_back('{g, err, p});
    tick();
    if (drop) req_valid = '0;
    check("mul_start", mul_start, 1);
    check("mul_a", mul_a, a);
    check("mul_b", mul_b, b);
    wait_rsp(n);
    check("latency", n, lat);
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; rsp_ready = '0;
    model_en = 1'b1; force_done = 1'b1; delay = 6;
    tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_rsp_err", rsp_err, 0);
    force_done = 1'b0;
    rst = 1'b1;
    #1;
    check("first_grant", req_ready, 2'b01);
    req_valid = '0;
    tick();
    check("withdraw_no_start", mul_start, 0);

    // single operation, 13*11
    req_a = 8'h0D; req_b = 8'h0B; req_valid = 2'b01; delay = 6;
    op(0, 4'd13, 4'd11, 1'b0, 7, 1'b1);
    rsp_ready = 2'b01;
    tick();
    check("single_rsp_drop", rsp_valid, 0);
    rsp_ready = '0;
    exp_ptr = 1;

    // contention, both requesters continuously valid
    req_a = {4'd7, 4'd3}; req_b = {4'd9, 4'd5}; rsp_ready = 2'b11;
    req_valid = 2'b11; delay = 2;
    for (int i = 0; i < 3; i++) begin
      op(exp_ptr, exp_ptr ? 4'd7 : 4'd3, exp_ptr ? 4'd9 : 4'd5, 1'b0, 3, 1'b0);
      tick();
      exp_ptr = (exp_ptr + 1) % NUM_REQ;
    end
    req_valid = '0; rsp_ready = '0;
    tick();

    // timeout, then a stray done while in RESP
    model_en = 1'b0;
    req_a = 8'h02; req_b = 8'h03; req_valid = 2'b01;
    op(0, 4'd2, 4'd3, 1'b1, TIMEOUT + 1, 1'b1);
    tick(); tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("stray_rsp_valid", rsp_valid, 2'b01);
    check("stray_rsp_err", rsp_err, 1);
    check("stray_rsp_product", rsp_product, 0);
    rsp_ready = 2'b01;
    tick();
    check("to_rsp_drop", rsp_valid, 0);
    rsp_ready = '0;
    model_en = 1'b1;

    // backpressure on requester 1, request held valid
    req_a = 8'h60; req_b = 8'h70; req_valid = 2'b10; delay = 4;
    op(1, 4'd6, 4'd7, 1'b0, 5, 1'b0);
    rsp_ready = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 2'b10);
      check("bp_rsp_product", rsp_product, 42);
      check("bp_rsp_err", rsp_err, 0);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 2'b10;
    #1;
    check("bp_ready_same_cycle", req_ready, 0);
    tick();
    check("bp_rsp_drop", rsp_valid, 0);
    check("bp_next_accept", req_ready, 2'b10);
    req_valid = '0; rsp_ready = '0;
    tick();
    check("bp_withdraw", mul_start, 0);

    // reset during WAIT
    req_a = 8'h04; req_b = 8'h04; req_valid = 2'b01; delay = 10;
    #1;
    check("mr_req_ready", req_ready, 2'b01);
    tick();
    check("mr_mul_start", mul_start, 1);
    req_valid = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("mr_mul_start_low", mul_start, 0);
    check("mr_mul_a", mul_a, 0);
    check("mr_mul_b", mul_b, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("mr_no_rsp", rsp_valid, 0);
    end
    exp_ptr = 0;
    req_a = 8'h0F; req_b = 8'h0F; req_valid = 2'b01; delay = 3;
    op(0, 4'd15, 4'd15, 1'b0, 4, 1'b1);
    rsp_ready = 2'b01;
    tick();
    check("mr_rsp_drop", rsp_valid, 0);
    rsp_ready = '0;
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
